tdc_hit_gen: RTL and testbench

- Programmable start/hit pulse-pair generator that drives the TDC input side (start, hit) from the clk domain.
- Provides known-interval stimulus for TDC calibration and code-density runs; captured results are read back through the existing thermometer-to-binary and out_bin path.
- Configured by a valid/ready word. Emits N pulse pairs with a fixed start-to-hit delay, then signals done.

---
 rtl/tdc_pkg.sv | 19 +
 rtl/tdc_pulse_win.sv | 24 ++
 rtl/tdc_hit_gen.sv | 112 +++++++++++
 tb/tb_tdc_hit_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared widths, state encoding and configuration word for the TDC hit generator.
package tdc_pkg;

    localparam int DLY_W = 8;
    localparam int WID_W = 4;
    localparam int GAP_W = 8;
    localparam int CNT_W = 16;

    typedef enum logic {IDLE, RUN} hitgen_state_t;

    typedef struct packed {
        logic [DLY_W-1:0] delay;
        logic [WID_W-1:0] width;
        logic [GAP_W-1:0] gap;
        logic [CNT_W-1:0] count;
        logic [DLY_W-1:0] step;
    } hitgen_cfg_t;

endpackage

// File: rtl/tdc_pulse_win.sv
// Registered window comparator: win goes high the cycle after lo <= t < lo+len.
module tdc_pulse_win #(
    parameter int T_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [T_W-1:0] t,
    input  logic [T_W-1:0] lo,
    input  logic [T_W-1:0] len,
    output logic           win
);

    logic [T_W:0] hi;

    // One extra bit so lo+len can never wrap below lo.
    assign hi = {1'b0, lo} + {1'b0, len};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) win <= 1'b0;
        else     win <= en && (t >= lo) && ({1'b0, t} < hi);
    end

endmodule

// File: rtl/tdc_hit_gen.sv
// Programmable start/hit pulse-pair generator for TDC calibration runs.
// Define TDC_HIT_GEN_SWEEP_EN to advance the start-to-hit delay by cfg_step after every pair.
module tdc_hit_gen
    import tdc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [DLY_W-1:0] cfg_step,
    input  logic             abort,
    output logic             start_o,
    output logic             hit_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_cnt
);

    localparam int T_W = DLY_W + 2;

    hitgen_state_t  state, state_nxt;
    hitgen_cfg_t    cfg_in, cfg_q;
    logic [T_W-1:0] t, d_ext, w_len, per_m1;
    logic           accept, pair_end, last_pair, run_en;

    always_comb begin
        cfg_in       = '0;
        cfg_in.delay = cfg_delay;
        cfg_in.width = cfg_width;
        cfg_in.gap   = cfg_gap;
        cfg_in.count = cfg_count;
        cfg_in.step  = cfg_step;
    end

    assign accept    = cfg_valid && (state == IDLE) && !abort;
    assign d_ext     = T_W'(cfg_q.delay);
    assign w_len     = (cfg_q.width == '0) ? T_W'(1) : T_W'(cfg_q.width);
    assign per_m1    = d_ext + w_len + T_W'(cfg_q.gap) - T_W'(1);
    assign pair_end  = (state == RUN) && (t == per_m1);
    assign last_pair = (cfg_q.count != '0) && ((pair_cnt + CNT_W'(1)) == cfg_q.count);
    assign run_en    = (state == RUN) && !abort;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (abort || (pair_end && last_pair)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cfg_q     <= '0;
            t         <= '0;
            pair_cnt  <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt == RUN);
            cfg_ready <= (state_nxt == IDLE);
            done      <= run_en && pair_end && last_pair;
            if (accept) begin
                cfg_q    <= cfg_in;
                t        <= '0;
                pair_cnt <= '0;
            end else if (run_en) begin
                t <= pair_end ? '0 : t + T_W'(1);
                if (pair_end) begin
                    pair_cnt <= pair_cnt + CNT_W'(1);
`ifdef TDC_HIT_GEN_SWEEP_EN
                    cfg_q.delay <= cfg_q.delay + cfg_q.step;
`endif
                end
            end
        end
    end

`ifndef TDC_HIT_GEN_SWEEP_EN
    logic step_unused;
    assign step_unused = ^cfg_q.step;
`endif

    // Pulse registers see t one cycle late, so the first start lands one cycle after acceptance.
    tdc_pulse_win #(.T_W(T_W)) u_start_win (
        .clk (clk),
        .rst (rst),
        .en  (run_en),
        .t   (t),
        .lo  ('0),
        .len (w_len),
        .win (start_o)
    );

    tdc_pulse_win #(.T_W(T_W)) u_hit_win (
        .clk (clk),
        .rst (rst),
        .en  (run_en),
        .t   (t),
        .lo  (d_ext),
        .len (w_len),
        .win (hit_o)
    );

endmodule

// File: tb/tb_tdc_hit_gen.sv
// Directed bench for tdc_hit_gen: per-cycle expected waveform scoreboard plus direct checks.
module tb_tdc_hit_gen;
    import tdc_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid, cfg_ready, abort;
    logic [DLY_W-1:0] cfg_delay, cfg_step;
    logic [WID_W-1:0] cfg_width;
    logic [GAP_W-1:0] cfg_gap;
    logic [CNT_W-1:0] cfg_count, pair_cnt;
    logic             start_o, hit_o, busy, done;

    tdc_hit_gen dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_gap   (cfg_gap),
        .cfg_count (cfg_count),
        .cfg_step  (cfg_step),
        .abort     (abort),
        .start_o   (start_o),
        .hit_o     (hit_o),
        .busy      (busy),
        .done      (done),
        .pair_cnt  (pair_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        st, ht, bz, dn, rd;
        logic [15:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   sr_q[$], hr_q[$];
    bit   rec_en = 1'b0;
    int   checks = 0, errors = 0;

    // Model of the run currently programmed into the DUT.
    int m_k, m_d0, m_w, m_g, m_cnt, m_step, m_abort;
    bit m_act = 1'b0;
`ifdef TDC_HIT_GEN_SWEEP_EN
    bit m_sweep = 1'b1;
`else
    bit m_sweep = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs in cycle c (interval after clock edge c).
    function automatic exp_t model_at(input int c);
        exp_t e;
        int s, d, p, n, u, t, nend, a, pc, ee;
        e.cyc = c; e.st = 0; e.ht = 0; e.bz = 0; e.dn = 0; e.rd = 1; e.pc = '0;
        if (!m_act || c < m_k) return e;
        a = (m_abort > 0) ? m_abort : 32'h7fff_ffff;
        s = m_k; d = m_d0; n = 0; u = c - 1; nend = -1; pc = 0;
        while (s <= c) begin
            if (m_cnt != 0 && n == m_cnt) begin nend = s; break; end
            p = d + m_w + m_g;
            if (u >= s && u < s + p && c < a) begin
                t = u - s;
                e.st = (t < m_w);
                e.ht = (t >= d && t < d + m_w);
            end
            if (s + p <= c && s + p < a) pc++;
            s += p; n++;
            if (m_sweep) d = (d + m_step) % 256;
        end
        ee = a;
        if (nend >= 0 && nend < ee) ee = nend;
        e.bz = (c < ee);
        e.rd = !e.bz;
        e.dn = (nend >= 0 && c == nend && nend < a);
        e.pc = 16'(pc);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            chk("sb_cyc", e.cyc, cyc);
            chk("start_o", start_o, e.st);
            chk("hit_o", hit_o, e.ht);
            chk("busy", busy, e.bz);
            chk("done", done, e.dn);
            chk("cfg_ready", cfg_ready, e.rd);
            chk("pair_cnt", pair_cnt, e.pc);
        end
    end

    logic prev_s = 1'b0, prev_h = 1'b0;
    always @(negedge clk) begin
        if (rec_en && start_o && !prev_s) sr_q.push_back(cyc);
        if (rec_en && hit_o && !prev_h) hr_q.push_back(cyc);
        prev_s <= start_o;
        prev_h <= hit_o;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin @(posedge clk); #1; end
    endtask

    task automatic set_cfg(input int d, input int w, input int g, input int c, input int st);
        cfg_delay = DLY_W'(d);
        cfg_width = WID_W'(w);
        cfg_gap   = GAP_W'(g);
        cfg_count = CNT_W'(c);
        cfg_step  = DLY_W'(st);
    endtask

    task automatic model_set(input int k, input int d, input int w, input int g,
                             input int c, input int st, input int a);
        m_k = k; m_d0 = d; m_w = (w == 0) ? 1 : w; m_g = g;
        m_cnt = c; m_step = st; m_abort = a; m_act = 1'b1;
    endtask

    // Called #1 after an edge; the config is accepted on the next edge k.
    task automatic start_run(input int d, input int w, input int g, input int c, input int st,
                             input int ab_off, input int npush, output int k);
        k = cyc + 1;
        set_cfg(d, w, g, c, st);
        cfg_valid = 1'b1;
        model_set(k, d, w, g, c, st, (ab_off > 0) ? k + ab_off : 0);
        for (int i = 0; i < npush; i++) sb_q.push_back(model_at(k + i));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb_q.size() > 0 && n < limit) begin @(negedge clk); n++; end
        chk("sb_drain", sb_q.size(), 0);
        sb_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, found;
        int exp_sp[4];

        rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        #7;
        chk("rst_start", start_o, 0);
        chk("rst_hit", hit_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pcnt", pair_cnt, 0);
        chk("rst_ready", cfg_ready, 1);
        wait_cyc(2);
        rst = 1'b0;

        // Basic pair, accepted on edge 10.
        wait_cyc(9);
        start_run(5, 2, 3, 1, 0, 0, 13, k);
        drain(40);

        // Zero width, zero delay, zero gap: P = 1.
        start_run(0, 0, 0, 3, 0, 0, 6, k);
        drain(20);

        // Free-run, abort while pair_cnt == 7 (pairs end every 8 cycles).
        start_run(4, 2, 2, 0, 0, 60, 66, k);
        wait_cyc(k + 59);
        abort = 1'b1;
        wait_cyc(k + 60);
        abort = 1'b0;
        drain(100);

        // Async reset in the middle of the second start pulse.
        start_run(3, 4, 2, 0, 0, 0, 0, k);
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(negedge clk);
            if (start_o === 1'b1 && pair_cnt != '0) found = 1;
        end
        chk("rst_mid_found", found, 1);
        #1 rst = 1'b1;
        #1;
        m_act = 1'b0;
        chk("arst_start", start_o, 0);
        chk("arst_hit", hit_o, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pcnt", pair_cnt, 0);
        wait_cyc(cyc + 2);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_busy2", busy, 0);
        @(posedge clk); #1;

        // Back-pressure: valid stays high with a different word during the run.
        start_run(2, 1, 1, 2, 0, 0, 9, k);
        set_cfg(7, 3, 0, 1, 5);
        cfg_valid = 1'b1;
        k2 = k + 9;
        model_set(k2, 7, 3, 0, 1, 5, 0);
        for (int c = k2; c <= k2 + 12; c++) sb_q.push_back(model_at(c));
        wait_cyc(k2);
        cfg_valid = 1'b0;
        drain(40);

        // Abort coincident with acceptance: nothing starts, state of previous run holds.
        k = cyc + 1;
        set_cfg(1, 1, 1, 1, 0);
        cfg_valid = 1'b1; abort = 1'b1;
        for (int c = k; c <= k + 3; c++) sb_q.push_back(model_at(c));
        @(posedge clk); #1;
        cfg_valid = 1'b0; abort = 1'b0;
        drain(10);

        // Delay sweep with 8-bit wrap.
        sr_q.delete(); hr_q.delete();
        rec_en = 1'b1;
        start_run(250, 1, 1, 4, 3, 0, 1012, k);
        drain(1100);
        rec_en = 1'b0;
        if (m_sweep) exp_sp = '{250, 253, 0, 3};
        else         exp_sp = '{250, 250, 250, 250};
        chk("sweep_starts", sr_q.size(), 4);
        chk("sweep_hits", hr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (sr_q.size() > i && hr_q.size() > i)
                chk("sweep_spacing", hr_q[i] - sr_q[i], exp_sp[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
